// File: rtl/queue_arbiter.sv
// queue_arbiter: round-robin two-producer front end for an external queue, with consumer handshake and flush drain
module queue_arbiter #(
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = 14,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [31:0]   data0,
  input  logic [31:0]   data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          q_push,
  output logic [31:0]   q_rear,
  output logic          q_pop,
  input  logic          q_empty,
  input  logic          q_full,
  input  logic [31:0]   q_front,
  output logic          out_valid,
  output logic [31:0]   out_data,
  input  logic          out_ready,
  input  logic          flush,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          almost_full
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic prio;
  logic run;
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (state == RUN) state_nx = flush ? FLUSH : RUN;
    else state_nx = (q_empty && !flush) ? RUN : FLUSH;
  end
  always_comb begin
    run = (state == RUN) && !flush;
    gnt0 = run && !q_full && req0 && (!req1 || !prio);
    gnt1 = run && !q_full && req1 && (!req0 || prio);
    q_push = gnt0 | gnt1;
    q_rear = gnt1 ? data1 : data0;
    out_valid = run && !q_empty;
    out_data = q_front;
    q_pop = (state == RUN) ? (out_valid && out_ready) : !q_empty;
    busy = (state == FLUSH);
    almost_full = count >= CW'(AF_LEVEL);
  end
  // The producer not just served becomes favoured for the next contended cycle
  always_ff @(posedge clk) begin
    if (!rst) prio <= 1'b0;
    else if (gnt0) prio <= 1'b1;
    else if (gnt1) prio <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst) count <= '0;
    else if (q_push && !q_pop && count != CW'(DEPTH)) count <= count + 1'b1;
    else if (q_pop && !q_push && count != '0) count <= count - 1'b1;
  end
endmodule

// File: tb/tb_queue_arbiter.sv
// tb_queue_arbiter: directed checks of queue_arbiter against a behavioural 16-entry queue
module tb_queue_arbiter;
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0, out_ready = 0, flush = 0, qclr = 0;
  logic [31:0] data0 = 0, data1 = 0;
  logic gnt0, gnt1, q_push, q_pop, out_valid, busy, almost_full;
  logic [31:0] q_rear, out_data, q_front;
  logic [4:0] count;
  logic q_empty, q_full;
  logic [31:0] mem [16];
  logic [3:0] rd = 0, wr = 0;
  logic [4:0] n = 0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  queue_arbiter #(.DEPTH(16), .AF_LEVEL(14)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .q_push(q_push), .q_rear(q_rear), .q_pop(q_pop),
    .q_empty(q_empty), .q_full(q_full), .q_front(q_front), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .flush(flush), .busy(busy),
    .count(count), .almost_full(almost_full)
  );

  assign q_empty = (n == 0);
  assign q_full = (n == 16);
  assign q_front = mem[rd];

  always @(posedge clk) begin
    if (qclr) begin
      rd <= 0;
      wr <= 0;
      n <= 0;
    end else begin
      if (q_push && !q_full) begin
        mem[wr] <= q_rear;
        wr <= wr + 1'b1;
      end
      if (q_pop && !q_empty) rd <= rd + 1'b1;
      n <= n + 5'(q_push && !q_full) - 5'(q_pop && !q_empty);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 0;
    qclr = 1;
    tick();
    rst = 1;
    qclr = 0;
  endtask

  task automatic push_seq(input int first, input int num);
    for (int i = 0; i < num; i++) begin
      req0 = 1;
      data0 = 32'(first + i);
      #1 chk("push_gnt", gnt0, 1);
      tick();
    end
    req0 = 0;
  endtask

  initial begin
    tick();
    tick();
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_push", q_push, 0);
    chk("rst_pop", q_pop, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    rst = 1;
    tick();

    req0 = 1;
    data0 = 32'h12345;
    #1;
    chk("first_gnt0", gnt0, 1);
    chk("first_gnt1", gnt1, 0);
    chk("first_push", q_push, 1);
    chk("first_rear", q_rear, 32'h12345);
    tick();
    req0 = 0;
    #1;
    chk("first_count", count, 1);
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 32'h12345);

    restart();
    req0 = 1;
    req1 = 1;
    for (int k = 0; k < 4; k++) begin
      data0 = 32'hA0 + 32'(k);
      data1 = 32'hB0 + 32'(k);
      #1;
      chk("rr_gnt0", gnt0, (k % 2) == 0);
      chk("rr_gnt1", gnt1, (k % 2) == 1);
      chk("rr_rear", q_rear, (k % 2) ? 32'hB0 + 32'(k) : 32'hA0 + 32'(k));
      tick();
    end
    req0 = 0;
    req1 = 0;
    #1 chk("rr_count", count, 4);

    restart();
    for (int i = 1; i <= 16; i++) begin
      req0 = 1;
      data0 = 32'(i);
      #1 chk("fill_gnt", gnt0, 1);
      tick();
      chk("fill_count", count, 32'(i));
      chk("fill_af", almost_full, i >= 14);
    end
    chk("full_flag", q_full, 1);
    #1;
    chk("full_gnt0", gnt0, 0);
    chk("full_push", q_push, 0);
    out_ready = 1;
    #1;
    chk("full_pop", q_pop, 1);
    chk("full_nopush", q_push, 0);
    chk("full_head", out_data, 1);
    tick();
    req0 = 0;
    out_ready = 0;
    #1;
    chk("full_count", count, 15);
    chk("full_af", almost_full, 1);

    restart();
    push_seq(1, 10);
    #1 chk("drain_start", count, 10);
    out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 32'(i));
      chk("drain_pop", q_pop, 1);
      tick();
    end
    #1;
    chk("drain_count", count, 0);
    chk("drain_valid11", out_valid, 0);
    chk("drain_pop11", q_pop, 0);
    out_ready = 0;

    push_seq(51, 5);
    #1 chk("fl_count5", count, 5);
    flush = 1;
    req0 = 1;
    #1;
    chk("fl_req_valid", out_valid, 0);
    chk("fl_req_gnt", gnt0, 0);
    tick();
    flush = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fl_busy", busy, 1);
      chk("fl_pop", q_pop, 1);
      chk("fl_gnt", gnt0, 0);
      chk("fl_valid", out_valid, 0);
      tick();
    end
    req0 = 0;
    #1;
    chk("fl_count0", count, 0);
    chk("fl_pop_empty", q_pop, 0);
    tick();
    chk("fl_done", busy, 0);

    push_seq(61, 3);
    flush = 1;
    tick();
    flush = 0;
    #1 chk("rf_busy", busy, 1);
    rst = 0;
    tick();
    rst = 1;
    #1;
    chk("rf_busy0", busy, 0);
    chk("rf_count0", count, 0);
    req0 = 1;
    req1 = 1;
    #1;
    chk("rf_prio_gnt0", gnt0, 1);
    chk("rf_prio_gnt1", gnt1, 0);
    req0 = 0;
    req1 = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
